// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath driven cycle-by-cycle by an external
// control word; holds accumulator, quotient/multiplier, divisor/multiplicand and count.
module muldiv_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic [4:0]       cs,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             count_zero,
  output logic             acc_neg,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   m_ext_s;

  assign m_ext_s = {1'b0, m_q};

  // Next-state decode: LOAD > SHIFT > ARITH > RESTORE; DEC rides alongside unless LOAD.
  always_comb begin
    acc_d  = acc_q;
    q_d    = q_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    done_d = done_q;
    if (cs[0]) begin
      acc_d  = '0;
      q_d    = a;
      m_d    = b;
      cnt_d  = CW'(WIDTH);
      mode_d = mode;
      done_d = 1'b0;
    end else begin
      if (cs[2]) begin
        if (mode_q) begin
          // A[WIDTH] is discarded: it is always clear after a restore step.
          acc_d = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {1'b0, acc_q[WIDTH:1]};
          q_d   = {acc_q[0], q_q[WIDTH-1:1]};
        end
      end else if (cs[1]) begin
        if (mode_q) begin
          acc_d = acc_q - m_ext_s;
        end else if (q_q[0]) begin
          acc_d = {1'b0, acc_q[WIDTH-1:0]} + m_ext_s;
        end else begin
          acc_d = acc_q;
        end
      end else if (cs[3]) begin
        if (mode_q) begin
          if (acc_q[WIDTH]) begin
            acc_d  = acc_q + m_ext_s;
            q_d[0] = 1'b0;
          end else begin
            q_d[0] = 1'b1;
          end
        end else begin
          acc_d = acc_q;
        end
      end else begin
        acc_d = acc_q;
      end

      if (cs[4]) begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CW'(1);
          done_d = (cnt_q == CW'(1)) ? 1'b1 : done_q;
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with synchronous reset overriding any command.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      q_q    <= q_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end

  assign result_hi  = acc_q[WIDTH-1:0];
  assign result_lo  = q_q;
  assign acc_neg    = acc_q[WIDTH];
  assign count_zero = (cnt_q == '0);
  assign done       = done_q;

endmodule

// File: tb/tb_muldiv_datapath.sv
// Self-checking bench for muldiv_datapath: arithmetic reference model compared after
// every clock edge, plus hand-computed result checks for the directed scenarios.
module tb_muldiv_datapath;

  localparam int W = 8;
  localparam logic [4:0] LOAD = 5'b00001;
  localparam logic [4:0] ARITH = 5'b00010;
  localparam logic [4:0] SHIFT = 5'b00100;
  localparam logic [4:0] RESTORE = 5'b01000;
  localparam logic [4:0] DEC = 5'b10000;

  logic         clock;
  logic         reset;
  logic         mode;
  logic [4:0]   cs;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
  logic         count_zero;
  logic         acc_neg;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference state as plain integers: acc in [0,512), q/m in [0,256)
  int m_acc, m_q, m_m, m_cnt, m_mode, m_done;

  muldiv_datapath #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .mode(mode), .cs(cs), .a(a), .b(b),
    .result_hi(result_hi), .result_lo(result_lo), .count_zero(count_zero),
    .acc_neg(acc_neg), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [4:0] c, input logic md,
                            input int av, input int bv);
    int aq;
    if (r) begin
      m_acc = 0; m_q = 0; m_m = 0; m_cnt = 0; m_mode = 0; m_done = 0;
    end else if (c[0]) begin
      m_acc = 0; m_q = av; m_m = bv; m_cnt = W; m_mode = int'(md); m_done = 0;
    end else begin
      if (c[2]) begin
        if (m_mode == 0) begin
          aq = (m_acc * 256 + m_q) / 2;
          m_acc = aq / 256;
          m_q = aq % 256;
        end else begin
          aq = ((m_acc % 256) * 256 + m_q) * 2;
          m_acc = aq / 256;
          m_q = aq % 256;
        end
      end else if (c[1]) begin
        if (m_mode == 0) begin
          if (m_q % 2 == 1) m_acc = (m_acc % 256) + m_m;
        end else begin
          m_acc = (m_acc - m_m + 512) % 512;
        end
      end else if (c[3]) begin
        if (m_mode == 1) begin
          if (m_acc >= 256) begin
            m_acc = (m_acc + m_m) % 512;
            m_q = m_q - (m_q % 2);
          end else begin
            m_q = m_q - (m_q % 2) + 1;
          end
        end
      end
      if (c[4] && m_cnt > 0) begin
        if (m_cnt == 1) m_done = 1;
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("result_hi", int'(result_hi), m_acc % 256);
    chk("result_lo", int'(result_lo), m_q);
    chk("acc_neg", int'(acc_neg), (m_acc >= 256) ? 1 : 0);
    chk("count_zero", int'(count_zero), (m_cnt == 0) ? 1 : 0);
    chk("done", int'(done), m_done);
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after it.
  task automatic cyc(input logic r, input logic [4:0] c, input logic md,
                     input logic [W-1:0] av, input logic [W-1:0] bv);
    reset = r; cs = c; mode = md; a = av; b = bv;
    @(posedge clock);
    model_step(r, c, md, int'(av), int'(bv));
    #1;
    compare_all();
  endtask

  task automatic mul_run(input logic [W-1:0] av, input logic [W-1:0] bv, input bit pin_done);
    cyc(1'b0, LOAD, 1'b0, av, bv);
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, ARITH, 1'b1, 8'h00, 8'h00);
      cyc(1'b0, SHIFT | DEC, 1'b1, 8'h00, 8'h00);
      if (pin_done) chk("mul_done_rise", int'(done), (i == W - 1) ? 1 : 0);
    end
  endtask

  task automatic div_run(input logic [W-1:0] av, input logic [W-1:0] bv);
    cyc(1'b0, LOAD, 1'b1, av, bv);
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, SHIFT, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, ARITH, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, RESTORE | DEC, 1'b0, 8'h00, 8'h00);
    end
  endtask

  initial begin
    reset = 1'b1; cs = 5'b00000; mode = 1'b0; a = 8'h00; b = 8'h00;

    // Reset dominates an all-ones control word
    cyc(1'b1, 5'b11111, 1'b1, 8'hAA, 8'h55);
    chk("rst_hi", int'(result_hi), 0);
    chk("rst_lo", int'(result_lo), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cz", int'(count_zero), 1);
    chk("rst_neg", int'(acc_neg), 0);
    cyc(1'b0, 5'b00000, 1'b0, 8'h00, 8'h00);

    mul_run(8'd200, 8'd250, 1'b1);
    chk("mul200x250_hi", int'(result_hi), 8'hC3);
    chk("mul200x250_lo", int'(result_lo), 8'h50);
    chk("mul200x250_done", int'(done), 1);
    cyc(1'b0, 5'b00000, 1'b1, 8'h11, 8'h22);

    mul_run(8'd255, 8'd255, 1'b0);
    chk("mul255x255_hi", int'(result_hi), 8'hFE);
    chk("mul255x255_lo", int'(result_lo), 8'h01);

    mul_run(8'd13, 8'd11, 1'b0);
    chk("mul13x11_hi", int'(result_hi), 8'h00);
    chk("mul13x11_lo", int'(result_lo), 8'h8F);

    div_run(8'd100, 8'd7);
    chk("div100by7_q", int'(result_lo), 8'h0E);
    chk("div100by7_r", int'(result_hi), 8'h02);
    chk("div100by7_neg", int'(acc_neg), 0);
    chk("div100by7_done", int'(done), 1);

    div_run(8'd100, 8'd0);
    chk("div0_q", int'(result_lo), 8'hFF);
    chk("div0_r", int'(result_hi), 8'h64);

    div_run(8'd255, 8'd1);
    chk("div255by1_q", int'(result_lo), 8'hFF);
    chk("div255by1_r", int'(result_hi), 8'h00);

    // Priority: SHIFT beats ARITH
    cyc(1'b0, LOAD, 1'b0, 8'h01, 8'h05);
    cyc(1'b0, 5'b00110, 1'b0, 8'h00, 8'h00);
    chk("prio_lo", int'(result_lo), 0);
    chk("prio_hi", int'(result_hi), 0);
    for (int i = 0; i < 10; i++) cyc(1'b0, DEC, 1'b0, 8'h00, 8'h00);
    chk("sat_cz", int'(count_zero), 1);
    chk("sat_done", int'(done), 1);
    cyc(1'b0, LOAD | DEC, 1'b0, 8'h01, 8'h05);
    chk("loaddec_cz", int'(count_zero), 0);
    chk("loaddec_done", int'(done), 0);
    for (int i = 0; i < 7; i++) cyc(1'b0, DEC, 1'b0, 8'h00, 8'h00);
    chk("loaddec_cnt7", int'(count_zero), 0);
    cyc(1'b0, DEC, 1'b0, 8'h00, 8'h00);
    chk("loaddec_cnt8", int'(count_zero), 1);

    // Abort a multiply with a divide load
    cyc(1'b0, LOAD, 1'b0, 8'd200, 8'd250);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, ARITH, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, SHIFT | DEC, 1'b0, 8'h00, 8'h00);
    end
    div_run(8'd9, 8'd3);
    chk("abort_q", int'(result_lo), 3);
    chk("abort_r", int'(result_hi), 0);
    chk("abort_done", int'(done), 1);

    // Reset mid-divide
    cyc(1'b0, LOAD, 1'b0, 8'd200, 8'd250);
    cyc(1'b0, ARITH, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, LOAD, 1'b1, 8'd9, 8'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, SHIFT, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, ARITH, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, RESTORE | DEC, 1'b0, 8'h00, 8'h00);
    end
    cyc(1'b0, SHIFT, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, ARITH | DEC, 1'b0, 8'h00, 8'h00);
    chk("midrst_hi", int'(result_hi), 0);
    chk("midrst_lo", int'(result_lo), 0);
    chk("midrst_cz", int'(count_zero), 1);
    chk("midrst_neg", int'(acc_neg), 0);
    chk("midrst_done", int'(done), 0);
    cyc(1'b0, 5'b00000, 1'b0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
